// File: rtl/ex_commit_ctrl.sv
// Exception/ERET commit controller at the end of WB: it prioritises exceptions, commits to CP0, flushes the pipe and redirects fetch.
// Optional feature: EX_BADVADDR_EN drives BadVAddr for address-error exceptions.
module ex_commit_ctrl #(
    parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic [6:0]  ws_exc_vec,
    input  logic        ws_eret,
    input  logic [31:0] ws_data_addr,
    output logic        ws_ready,
    output logic        ws_cancel,
    input  logic        c0_status_ie,
    input  logic        c0_status_exl,
    input  logic [7:0]  c0_status_im,
    input  logic [7:0]  c0_cause_ip,
    input  logic [31:0] c0_epc,
    output logic        wb_ex,
    output logic [4:0]  wb_excode,
    output logic        wb_bd,
    output logic [31:0] wb_pc,
    output logic        eret_flush,
    output logic [31:0] wb_badvaddr,
    output logic        wb_badvaddr_we,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH, S_REDIRECT} state_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state, w_next;
    logic [4:0]  r_excode;
    logic        r_bd;
    logic [31:0] r_pc;
    logic        r_is_eret;
    logic [31:0] r_epc;
    logic [3:0]  r_cnt;

    logic        w_int_pend, w_any_exc, w_take, w_eret_only;
    logic [4:0]  w_excode;
    logic        w_addr_if, w_addr_d;

    assign w_int_pend  = c0_status_ie & ~c0_status_exl & (|(c0_status_im & c0_cause_ip));
    assign w_any_exc   = w_int_pend | (|ws_exc_vec);
    assign w_take      = ws_valid & ws_ready & (w_any_exc | ws_eret);
    assign w_eret_only = ws_eret & ~w_any_exc;
    assign ws_cancel   = w_take & ~w_eret_only;

    // vec bits: {ades,adel_d,ov,bp,sys,ri,adel_if}
    always_comb begin
        w_excode  = EXC_INT;
        w_addr_if = 1'b0;
        w_addr_d  = 1'b0;
        if (w_int_pend) begin
            w_excode = EXC_INT;
        end else if (ws_exc_vec[0]) begin
            w_excode  = EXC_ADEL;
            w_addr_if = 1'b1;
        end else if (ws_exc_vec[1]) begin
            w_excode = EXC_RI;
        end else if (ws_exc_vec[4]) begin
            w_excode = EXC_OV;
        end else if (ws_exc_vec[2]) begin
            w_excode = EXC_SYS;
        end else if (ws_exc_vec[3]) begin
            w_excode = EXC_BP;
        end else if (ws_exc_vec[5]) begin
            w_excode = EXC_ADEL;
            w_addr_d = 1'b1;
        end else if (ws_exc_vec[6]) begin
            w_excode = EXC_ADES;
            w_addr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_excode  <= 5'd0;
            r_bd      <= 1'b0;
            r_pc      <= 32'd0;
            r_is_eret <= 1'b0;
            r_epc     <= 32'd0;
            r_cnt     <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_excode  <= w_excode;
                r_bd      <= ws_bd;
                r_pc      <= ws_pc;
                r_is_eret <= w_eret_only;
                r_epc     <= c0_epc;
            end
            if (r_state == S_COMMIT)
                r_cnt <= CNT_INIT;
            else if (r_state == S_FLUSH && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

`ifdef EX_BADVADDR_EN
    logic [31:0] r_badvaddr;
    logic        r_bv_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_badvaddr <= 32'd0;
            r_bv_we    <= 1'b0;
        end else if (w_take) begin
            r_badvaddr <= w_addr_if ? ws_pc : ws_data_addr;
            r_bv_we    <= w_addr_if | w_addr_d;
        end
    end

    assign wb_badvaddr    = wb_ex ? r_badvaddr : 32'd0;
    assign wb_badvaddr_we = wb_ex & r_bv_we;
`else
    logic w_unused_bv;
    assign w_unused_bv    = ^{ws_data_addr, w_addr_if, w_addr_d};
    assign wb_badvaddr    = 32'd0;
    assign wb_badvaddr_we = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_take) w_next = S_COMMIT;
            S_COMMIT:   w_next = S_FLUSH;
            S_FLUSH:    if (r_cnt == 4'd0) w_next = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Commit fields are gated so CP0 only ever sees them alongside the strobe.
    always_comb begin
        ws_ready       = 1'b0;
        wb_ex          = 1'b0;
        eret_flush     = 1'b0;
        wb_excode      = 5'd0;
        wb_bd          = 1'b0;
        wb_pc          = 32'd0;
        pipe_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (r_state)
            S_IDLE: ws_ready = 1'b1;
            S_COMMIT: begin
                pipe_flush = 1'b1;
                if (r_is_eret) begin
                    eret_flush = 1'b1;
                end else begin
                    wb_ex     = 1'b1;
                    wb_excode = r_excode;
                    wb_bd     = r_bd;
                    wb_pc     = r_pc;
                end
            end
            S_FLUSH: pipe_flush = 1'b1;
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_is_eret ? r_epc : EX_ENTRY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ex_commit_ctrl.sv
// Randomised bench for ex_commit_ctrl against a transaction-level priority/timing model.
module tb_ex_commit_ctrl;
    localparam int          FC    = 2;
    localparam logic [31:0] ENTRY = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid, ws_bd, ws_eret;
    logic [31:0] ws_pc, ws_data_addr, c0_epc;
    logic [6:0]  ws_exc_vec;
    logic        ws_ready, ws_cancel;
    logic        c0_status_ie, c0_status_exl;
    logic [7:0]  c0_status_im, c0_cause_ip;
    logic        wb_ex, wb_bd, eret_flush, wb_badvaddr_we;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc, wb_badvaddr, redirect_pc;
    logic        pipe_flush, redirect_valid, redirect_ready;

    int nvec = 0;
    int nerr = 0;

    ex_commit_ctrl #(.EX_ENTRY(ENTRY), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd), .ws_exc_vec(ws_exc_vec),
        .ws_eret(ws_eret), .ws_data_addr(ws_data_addr),
        .ws_ready(ws_ready), .ws_cancel(ws_cancel),
        .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
        .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc),
        .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
        .eret_flush(eret_flush), .wb_badvaddr(wb_badvaddr), .wb_badvaddr_we(wb_badvaddr_we),
        .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exceptions listed from highest to lowest priority as (vec bit, ExcCode).
    function automatic void model(input logic [6:0] ev, input logic eret, input logic ie, input logic exl,
                                  input logic [7:0] im, input logic [7:0] ip, input logic [31:0] pc,
                                  input logic [31:0] da, output logic take, output logic is_exc,
                                  output logic [4:0] code, output logic [31:0] bv, output logic bvwe);
        int  order [7];
        int  codes [7];
        bit  intp;
        order = '{0, 1, 4, 2, 3, 5, 6};
        codes = '{4, 10, 12, 8, 9, 4, 5};
        intp   = ie && !exl && ((im & ip) != 8'd0);
        is_exc = intp || (ev != 7'd0);
        take   = is_exc || eret;
        code   = 5'd0;
        bv     = 32'd0;
        bvwe   = 1'b0;
        if (!intp) begin
            for (int i = 6; i >= 0; i--) begin
                if (ev[order[i]]) begin
                    code = 5'(codes[i]);
`ifdef EX_BADVADDR_EN
                    bvwe = (order[i] == 0) || (order[i] >= 5);
                    bv   = (order[i] == 0) ? pc : (order[i] >= 5 ? da : 32'd0);
`endif
                end
            end
        end
    endfunction

    task automatic scramble(input logic rdy);
        ws_valid       = 1'($urandom);
        ws_exc_vec     = 7'($urandom);
        ws_eret        = 1'($urandom);
        ws_pc          = $urandom;
        ws_bd          = 1'($urandom);
        ws_data_addr   = $urandom;
        c0_epc         = $urandom;
        c0_status_ie   = 1'($urandom);
        c0_status_exl  = 1'($urandom);
        c0_cause_ip    = 8'($urandom);
        redirect_ready = rdy;
    endtask

    task automatic txn(input logic [6:0] ev, input logic eret, input logic ie, input logic exl,
                       input logic [7:0] im, input logic [7:0] ip, input logic [31:0] pc,
                       input logic [31:0] da, input logic [31:0] epc, input logic bd, input int dly);
        logic        take, is_exc, bvwe;
        logic [4:0]  code;
        logic [31:0] bv, rpc;
        model(ev, eret, ie, exl, im, ip, pc, da, take, is_exc, code, bv, bvwe);
        ws_valid = 1'b1; ws_exc_vec = ev; ws_eret = eret; c0_status_ie = ie; c0_status_exl = exl;
        c0_status_im = im; c0_cause_ip = ip; ws_pc = pc; ws_data_addr = da; c0_epc = epc; ws_bd = bd;
        redirect_ready = 1'($urandom);
        #1;
        chk("idle_ready", 32'(ws_ready), 32'd1);
        chk("cancel", 32'(ws_cancel), 32'(take && is_exc));
        if (!take) begin
            @(negedge clk);
            chk("notake_ready", 32'(ws_ready), 32'd1);
            chk("notake_flush", 32'(pipe_flush), 32'd0);
            ws_valid = 1'b0;
            return;
        end
        rpc = is_exc ? ENTRY : epc;
        @(negedge clk);
        chk("c_wb_ex", 32'(wb_ex), 32'(is_exc));
        chk("c_eret", 32'(eret_flush), 32'(!is_exc));
        chk("c_flush", 32'(pipe_flush), 32'd1);
        chk("c_ready", 32'(ws_ready), 32'd0);
        chk("c_rv", 32'(redirect_valid), 32'd0);
        if (is_exc) begin
            chk("c_excode", 32'(wb_excode), 32'(code));
            chk("c_bd", 32'(wb_bd), 32'(bd));
            chk("c_pc", wb_pc, pc);
            chk("c_bv", wb_badvaddr, bv);
            chk("c_bvwe", 32'(wb_badvaddr_we), 32'(bvwe));
        end
        scramble(1'($urandom));
        for (int i = 0; i < FC; i++) begin
            @(negedge clk);
            chk("f_flush", 32'(pipe_flush), 32'd1);
            chk("f_strobe", 32'(wb_ex | eret_flush), 32'd0);
            chk("f_rv", 32'(redirect_valid), 32'd0);
            chk("f_ready", 32'(ws_ready), 32'd0);
            scramble(1'($urandom));
        end
        for (int k = 0; k <= dly; k++) begin
            @(negedge clk);
            chk("r_rv", 32'(redirect_valid), 32'd1);
            chk("r_pc", redirect_pc, rpc);
            chk("r_flush", 32'(pipe_flush), 32'd0);
            chk("r_ready", 32'(ws_ready), 32'd0);
            chk("r_strobe", 32'(wb_ex | eret_flush), 32'd0);
            scramble(k == dly);
        end
        ws_valid = 1'b0;
        @(negedge clk);
        chk("i_ready", 32'(ws_ready), 32'd1);
        chk("i_rv", 32'(redirect_valid), 32'd0);
        chk("i_flush", 32'(pipe_flush), 32'd0);
        ws_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] ev;
        int         mode;
        reset = 1'b1;
        ws_valid = 1'b0; ws_pc = '0; ws_bd = 1'b0; ws_exc_vec = '0; ws_eret = 1'b0; ws_data_addr = '0;
        c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_im = '0; c0_cause_ip = '0; c0_epc = '0;
        redirect_ready = 1'b0;
        #1;
        chk("rst_ready", 32'(ws_ready), 32'd1);
        chk("rst_wb_ex", 32'(wb_ex), 32'd0);
        chk("rst_eret", 32'(eret_flush), 32'd0);
        chk("rst_flush", 32'(pipe_flush), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        txn(7'b0000100, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'hbfc00100, 32'h0, 32'h0, 1'b0, 0);
        txn(7'b0010011, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'hbfc00200, 32'h1234, 32'h0, 1'b1, 1);
        txn(7'b0000100, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 32'hbfc00300, 32'h0, 32'h0, 1'b0, 0);
        txn(7'b0000100, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 32'hbfc00300, 32'h0, 32'h0, 1'b0, 0);
        txn(7'b0000000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'hbfc00400, 32'h0, 32'hbfc01234, 1'b0, 0);
        txn(7'b0000010, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'hbfc00500, 32'h0, 32'hbfc01234, 1'b0, 0);
        txn(7'b1000000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'hbfc00600, 32'h8000_0003, 32'h0, 1'b0, 5);
        txn(7'b0100000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'hbfc00700, 32'h8000_0001, 32'h0, 1'b1, 2);

        // Pending interrupt with no WB instruction must not be taken.
        ws_valid = 1'b0; c0_status_ie = 1'b1; c0_status_exl = 1'b0; c0_status_im = 8'hff; c0_cause_ip = 8'h80;
        repeat (3) begin
            @(negedge clk);
            chk("noval_ready", 32'(ws_ready), 32'd1);
            chk("noval_flush", 32'(pipe_flush), 32'd0);
        end

        // Async reset while flushing.
        ws_valid = 1'b1; ws_exc_vec = 7'b0000100; ws_eret = 1'b0; c0_status_ie = 1'b0;
        @(negedge clk);
        ws_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_flush", 32'(pipe_flush), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_flush", 32'(pipe_flush), 32'd0);
        chk("mid_rst_ready", 32'(ws_ready), 32'd1);
        chk("mid_rst_wb_ex", 32'(wb_ex), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        redirect_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_rv", 32'(redirect_valid), 32'd0);
            chk("post_rst_flush", 32'(pipe_flush), 32'd0);
        end

        for (int n = 0; n < 200; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       ev = 7'(1 << $urandom_range(0, 6));
                1:       ev = 7'($urandom);
                default: ev = 7'd0;
            endcase
            txn(ev, (mode == 3) ? 1'b1 : 1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
                int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("gap_ready", 32'(ws_ready), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
